// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch stage between instruction memory and the IF/ID register.
// Issues sequential word fetches, buffers returned instructions with their PCs in a small FIFO
// and presents one instruction per cycle to decode. A decode stall holds the head entry; a taken
// branch redirect flushes the FIFO, discards in-flight responses and refetches from the target.
//
// Optional feature: define FETCHQ_STATS_EN to add the flush_cnt statistics output.
//
// Ports:
//   clk, rst          core clock, asynchronous active-low reset
//   imem_req/addr     fetch request and word address (memory always accepts)
//   imem_rvalid/rdata in-order fetch response, latency >= 1 cycle
//   stall             decode hazard, hold the head entry
//   redirect/_pc      taken branch from decode and its target
//   out_valid/instr/pc head entry presented to decode (0/0 when empty)
//   queue_count       number of buffered entries
//   flush_cnt         (FETCHQ_STATS_EN only) saturating count of flushed/discarded fetches
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req,
  output logic [31:0]             imem_addr,
  input  logic                    imem_rvalid,
  input  logic [31:0]             imem_rdata,
  input  logic                    stall,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  output logic                    out_valid,
  output logic [31:0]             out_instr,
  output logic [31:0]             out_pc,
  output logic [$clog2(DEPTH):0]  queue_count
`ifdef FETCHQ_STATS_EN
  ,
  output logic [15:0]             flush_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DepthW = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic          empty, resp_ok, drop, issue, push, pop;
  logic [31:0]   redirect_base;
  logic [CW-1:0] discard_left;

  assign empty         = (count_q == '0);
  // A response with nothing outstanding is a protocol violation and is ignored.
  assign resp_ok       = imem_rvalid && (outst_q != '0);
  assign drop          = (discard_q != '0);
  assign redirect_base = {redirect_pc[31:2], 2'b00};

  // Outputs
  always_comb begin
    // Buffered plus in-flight fetches never exceed DEPTH, so a push can never overflow.
    imem_req    = rst && !redirect && (({1'b0, count_q} + {1'b0, outst_q}) < DepthW);
    imem_addr   = fetch_pc_q;
    out_valid   = !empty && !redirect;
    out_instr   = empty ? 32'h0 : instr_mem[rd_ptr_q];
    out_pc      = empty ? 32'h0 : pc_mem[rd_ptr_q];
    queue_count = count_q;
  end

  assign issue = imem_req;
  assign push  = resp_ok && !drop && !redirect;
  assign pop   = out_valid && !stall;

  // Next state
  always_comb begin
    discard_left = discard_q - CW'(resp_ok && drop);
    outst_d      = outst_q + CW'(issue) - CW'(resp_ok);
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    discard_d    = discard_left;
    if (redirect) begin
      // Everything still in flight belongs to the wrong path.
      fetch_pc_d = redirect_base;
      resp_pc_d  = redirect_base;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      discard_d  = outst_d;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)  resp_pc_d  = resp_pc_q + 32'd4;
      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= resp_pc_q;
    end
  end

`ifdef FETCHQ_STATS_EN
  logic [15:0] flush_cnt_q;
  logic [16:0] flush_sum;

  // Flushed entries plus responses newly marked for discard (already-marked ones are not recounted).
  always_comb begin
    flush_sum = {1'b0, flush_cnt_q} + 17'(count_q) + 17'(outst_d - discard_left);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt_q <= 16'h0;
    end else if (redirect) begin
      flush_cnt_q <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end
  end

  assign flush_cnt = flush_cnt_q;
`endif

  stray_response: assert property (@(posedge clk) disable iff (!rst)
                                   !(imem_rvalid && (outst_q == '0)))
    else $error("fetch_queue: imem_rvalid with no outstanding request");

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  queue_count;
`ifdef FETCHQ_STATS_EN
  logic [15:0] flush_cnt;
`endif

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .queue_count (queue_count)
`ifdef FETCHQ_STATS_EN
    ,
    .flush_cnt   (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
    int          ep;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  req_t mem_q[$];   // requests in flight inside the memory model
  ent_t sb_q[$];    // expected instructions, in delivery order

  int          vec   = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          lat   = 1;
  int          last_due = -1;
  int          epoch = 0;
  int          pend_s = 0;
  int          first_valid_cyc = -1;
  bit          mon_en = 1'b0;
  logic [31:0] exp_fetch = 32'h0;
  int          flush_m = 0;

  bit          deliv;
  logic [31:0] deliv_addr;
  int          deliv_ep;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: in-order responses, configurable latency, data = addr ^ A5A5_0000.
  always @(negedge clk) begin
    if (!rst) begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      deliv       = 1'b0;
      mem_q.delete();
    end else begin
      deliv = 1'b0;
      if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
        req_t r;
        r = mem_q.pop_front();
        deliv      = 1'b1;
        deliv_addr = r.addr;
        deliv_ep   = r.ep;
        imem_rvalid = 1'b1;
        imem_rdata  = r.addr ^ 32'hA5A5_0000;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end
      #1;
      pend_s = mem_q.size() + (deliv ? 1 : 0);
      if (imem_req) begin
        req_t n;
        n.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        n.addr = imem_addr;
        n.ep   = epoch;
        last_due = n.due;
        mem_q.push_back(n);
      end
      #3;
      // A response from before the latest redirect (or in its cycle) never reaches decode.
      if (deliv && deliv_ep == epoch) begin
        ent_t e;
        e.pc    = deliv_addr;
        e.instr = deliv_addr ^ 32'hA5A5_0000;
        sb_q.push_back(e);
      end
      cyc++;
    end
  end

  // Monitor: compares DUT against the model every cycle, then advances the model.
  always @(negedge clk) begin
    int   sz;
    int   n_cur;
    logic ev;
    logic er;
    ent_t h;
    #3;
    if (mon_en) begin
      sz = sb_q.size();
      ev = (sz != 0) && !redirect;
      er = !redirect && (sz + pend_s < DEPTH);
      chk("queue_count", 32'(queue_count), 32'(sz));
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("imem_req", 32'(imem_req), 32'(er));
      if (er) chk("imem_addr", imem_addr, exp_fetch);
      if (sz == 0) begin
        chk("empty_out_instr", out_instr, 32'h0);
        chk("empty_out_pc", out_pc, 32'h0);
      end else if (!redirect) begin
        chk("out_pc", out_pc, sb_q[0].pc);
        chk("out_instr", out_instr, sb_q[0].instr);
      end
`ifdef FETCHQ_STATS_EN
      chk("flush_cnt", 32'(flush_cnt), 32'(flush_m));
`endif
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (redirect) begin
        n_cur = 0;
        foreach (mem_q[i]) if (mem_q[i].ep == epoch) n_cur++;
        flush_m = (flush_m + sz + n_cur > 65535) ? 65535 : flush_m + sz + n_cur;
        epoch++;
        sb_q.delete();
        exp_fetch = {redirect_pc[31:2], 2'b00};
      end else begin
        if (er) exp_fetch = exp_fetch + 32'd4;
        if (ev && !stall) h = sb_q.pop_front();
      end
    end
  end

  task automatic drive(input logic s, input logic r, input logic [31:0] p);
    @(negedge clk);
    stall       = s;
    redirect    = r;
    redirect_pc = p;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_imem_req", 32'(imem_req), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_instr", out_instr, 32'h0);
    chk("reset_out_pc", out_pc, 32'h0);
    chk("reset_queue_count", 32'(queue_count), 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    mon_en = 1'b1;

    // Streaming at latency 1
    repeat (12) drive(1'b0, 1'b0, 32'h0);
    chk("first_valid_cycle", 32'(first_valid_cyc), 32'd2);

    // Stall long enough to fill the queue
    repeat (10) drive(1'b1, 1'b0, 32'h0);
    #2;
    chk("stall_full_count", 32'(queue_count), 32'd4);
    chk("stall_full_req", 32'(imem_req), 32'h0);
    repeat (10) drive(1'b0, 1'b0, 32'h0);

    // Redirect with latency-3 responses in flight
    lat = 3;
    repeat (6) drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h0000_0100);
    repeat (12) drive(1'b0, 1'b0, 32'h0);

    // Redirect and stall together with three entries buffered
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      stall    = 1'b1;
      redirect = 1'b0;
      if (queue_count == 3'd3) begin
        found       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
      end
    end
    chk("reach_three_entries", 32'(found), 32'h1);
    if (found) begin
      #2;
      chk("redir_stall_out_valid", 32'(out_valid), 32'h0);
      drive(1'b0, 1'b0, 32'h0);
      #2;
      chk("redir_stall_flushed", 32'(queue_count), 32'h0);
      chk("redir_stall_fetch_addr", imem_addr, 32'h0000_0200);
    end
    repeat (8) drive(1'b0, 1'b0, 32'h0);

    // Unaligned redirect target
    drive(1'b0, 1'b1, 32'h0000_0103);
    drive(1'b0, 1'b0, 32'h0);
    #2;
    chk("redir_unaligned_addr", imem_addr, 32'h0000_0100);
    repeat (8) drive(1'b0, 1'b0, 32'h0);

    // Fetch PC wrap
    lat = 2;
    drive(1'b0, 1'b1, 32'hFFFF_FFF0);
    repeat (14) drive(1'b0, 1'b0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] p;
      if (i % 100 == 0) lat = int'($urandom_range(1, 4));
      p = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, p);
    end

    repeat (20) drive(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

endmodule
